key_conditioner: RTL
====================

// Module: key_conditioner
// PURPOSE
//  Front-end for the digitalLock state machine. Takes the four raw active-low push-buttons,
//  synchronises and debounces them, and rejects multi-key presses.
//  Emits one single-cycle one-hot pulse per accepted press on key[3:0].
//  key[3:0] drives digitalLock.key directly; between presses it is 4'b0000.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  clocks the input must be stable to accept a press or release (20 ms @ 50 MHz); must be >= 2
//  REPEAT_CYCLES    25000000 clocks between auto-repeat pulses while a key is held; used only with KEY_REPEAT_EN
// PORTS
//  clock    in   1  system clock
//  reset    in   1  asynchronous reset, active-low
//  keyRaw   in   4  raw push-buttons, active-low (0 = pressed), asynchronous to clock
//  key      out  4  one-hot press pulse, 1 clock wide, registered
//  busy     out  1  high whenever the FSM is not in IDLE (press in progress or key held)
// BEHAVIOUR
//  - Reset, asserted at any time including mid-debounce:
//    - key=0, busy=0, state=IDLE, counters=0.
//    - Both synchroniser stages preset to 4'b1111 (released).
//  - Synchroniser: 2-flop per bit. keySync = ~stage2, so 1 = pressed.
//  - Counter width is $clog2(max(DEBOUNCE_CYCLES,REPEAT_CYCLES)).
//  - Counter clears on every state entry and increments once per clock otherwise.
//  - FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
//    - IDLE:
//      - keySync has exactly one bit set: latch it as keyLatch, go to PRESS_DB.
//      - keySync is 0, or has more than one bit set: stay in IDLE.
//    - PRESS_DB:
//      - keySync != keyLatch (released, or another key joined): go to IDLE, no pulse.
//      - Otherwise, when count == DEBOUNCE_CYCLES-1: key <= keyLatch for one clock, go to HELD.
//    - HELD:
//      - keySync == 0: go to RELEASE_DB.
//      - Any key pressed, including extra keys: stay in HELD, no new pulse.
//    - RELEASE_DB:
//      - Any keySync bit set: go back to HELD, no pulse.
//      - Otherwise, when count == DEBOUNCE_CYCLES-1: go to IDLE.
//  - Latency: a clean press that is low from rising edge N gives key high in the cycle after edge N+DEBOUNCE_CYCLES+2.
//    - 2 edges for synchronisation, 1 for the IDLE decision, DEBOUNCE_CYCLES for the count.
//  - key is never multi-hot, and is never high for two consecutive cycles.
//  - A held key produces exactly one pulse; the next pulse needs a debounced release first.
//  - Bounce during PRESS_DB restarts the whole acceptance, because the FSM returns to IDLE.
//  - busy = (state != IDLE), registered together with state.
// CONFIGURATION
//  - KEY_REPEAT_EN defined:
//    - In HELD with keySync == keyLatch, count runs.
//    - When count == REPEAT_CYCLES-1: key <= keyLatch for one clock and count clears.
//    - Extra keys (keySync != keyLatch but nonzero) hold count at 0 until only keyLatch remains.
//  - KEY_REPEAT_EN undefined:
//    - HELD count is unused and REPEAT_CYCLES is ignored.
//    - Exactly one pulse per press.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
//  1. Reset low for 2 clocks, keyRaw=4'hF -> key=0, busy=0 throughout and after release.
//  2. keyRaw=4'hE (key0) held for 20 clocks -> key=4'b0001 for exactly 1 clock, 7 clocks after keyRaw falls; busy=1.
//     Then keyRaw=4'hF -> busy=0 after 4+3 clocks.
//  3. keyRaw=4'hB toggling 4'hF every 2 clocks for 10 clocks, then stable -> no pulse during bounce.
//     Single key=4'b0100 exactly 7 clocks after the last bounce.
//  4. keyRaw=4'hC (two keys) for 20 clocks -> key stays 0, busy stays 0.
//  5. Reset asserted mid-PRESS_DB (2 clocks into the count) -> key=0, busy=0 immediately.
//     No pulse after reset releases until the key is stable for another 7 clocks.
//  6. KEY_REPEAT_EN: keyRaw=4'h7 held for 40 clocks -> key=4'b1000 at +7, then every 8 clocks (+15, +23, +31, +39).
//     Without the macro: one pulse only.

Source files
------------

// File: rtl/key_conditioner.sv
// Push-button front end: 2-flop sync, debounce, multi-key reject, one-hot press pulse.
// Define KEY_REPEAT_EN to emit auto-repeat pulses while a single key stays held.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keyRaw,
    output logic [3:0] key,
    output logic       busy
);

    localparam int MAX_CYCLES =
        (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);
`endif

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_PRESS_DB   = 2'd1;
    localparam logic [1:0] S_HELD       = 2'd2;
    localparam logic [1:0] S_RELEASE_DB = 2'd3;

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    latch_q, latch_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    key_q, key_d;
    logic          busy_q, busy_d;

    logic [3:0] key_sync;
    logic       key_onehot;

    // Raw buttons are active-low; both stages rest at "released".
    always_comb begin
        sync1_d = keyRaw;
        sync2_d = sync1_q;
    end

    assign key_sync   = ~sync2_q;
    assign key_onehot = (|key_sync) && ~(|(key_sync & (key_sync - 4'd1)));

    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        count_d = count_q + CW'(1);
        key_d   = 4'b0000;
        unique case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (key_onehot) begin
                    latch_d = key_sync;
                    state_d = S_PRESS_DB;
                end
            end
            S_PRESS_DB: begin
                if (key_sync != latch_q) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (count_q == DB_LAST) begin
                    key_d   = latch_q;
                    state_d = S_HELD;
                    count_d = '0;
                end
            end
            S_HELD: begin
                if (key_sync == 4'b0000) begin
                    state_d = S_RELEASE_DB;
                    count_d = '0;
                end else begin
`ifdef KEY_REPEAT_EN
                    // Extra keys freeze the repeat timer at zero.
                    if (key_sync != latch_q) begin
                        count_d = '0;
                    end else if (count_q == RPT_LAST) begin
                        key_d   = latch_q;
                        count_d = '0;
                    end
`else
                    count_d = '0;
`endif
                end
            end
            S_RELEASE_DB: begin
                if (key_sync != 4'b0000) begin
                    state_d = S_HELD;
                    count_d = '0;
                end else if (count_q == DB_LAST) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
            state_q <= S_IDLE;
            latch_q <= 4'b0000;
            count_q <= '0;
            key_q   <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            latch_q <= latch_d;
            count_q <= count_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
        end
    end

    assign key  = key_q;
    assign busy = busy_q;

endmodule
